// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Free-running supervisor clocked by the PLL reference clock. It sequences
// the PLL reset, qualifies the PLL locked indication over a stability window,
// and holds downstream logic in reset (sys_rst) until the generated clock can
// be trusted. A lock attempt that times out is retried a bounded number of
// times. After that, the block latches a fault that only rst clears.
//
// Ports:
//   refclk        in   free-running reference clock. All logic uses its rising edge.
//   rst           in   asynchronous active-high reset
//   locked        in   PLL locked, asynchronous to refclk
//   pll_rst       out  reset to the PLL, active high
//   sys_rst       out  system reset request, active high
//   ready         out  high while in RUN
//   fault         out  high while in FAULT (sticky until rst)
//   lock_lost_cnt out  lock losses seen in RUN, saturates at 255
//   retry_cnt     out  failed lock attempts since the last RUN
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int POR_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_lost_cnt,
    output logic [7:0] retry_cnt
);

    // One phase counter serves every state, so it is sized for the longest window.
    localparam int MAX_A   = (POR_CYCLES > LOCK_STABLE_CYCLES) ? POR_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             pll_rst_d, sys_rst_d, ready_d, fault_d;

    // Two-flop synchronizer for the asynchronous locked input.
    logic locked_p0;
    logic locked_s;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_p0 <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            locked_p0 <= locked;
            locked_s  <= locked_p0;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        // The counter only matters in the timed states. Saturating it keeps
        // it from wrapping during a long stay in RUN or FAULT.
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == POR_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout that lands on the same cycle.
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                    state_d = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // Every state entry restarts the phase window. This includes a
        // STABLE->WAIT_LOCK abort, so the timeout window also restarts.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if ((state_d == S_RUN) && (state_q != S_RUN)) begin
            retry_d = 8'd0;
        end

        // Outputs are decoded from the next state so they are registered and
        // change on the same edge as the state register.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= 8'd0;
            lost_q  <= 8'd0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
            pll_rst <= pll_rst_d;
            sys_rst <= sys_rst_d;
            ready   <= ready_d;
            fault   <= fault_d;
        end
    end

    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule
